// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter/rotator: one register stage per shift level, global stall.
// Optional registered zero flag on the result when SHIFTER_ZERO_FLAG_EN is defined.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [2:0]               in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_illegal
`ifdef SHIFTER_ZERO_FLAG_EN
  ,
  output logic                     out_zero
`endif
);

  localparam int unsigned L = $clog2(WIDTH);

  localparam logic [2:0] OpSll = 3'b000;
  localparam logic [2:0] OpSrl = 3'b001;
  localparam logic [2:0] OpSra = 3'b011;
  localparam logic [2:0] OpRol = 3'b100;
  localparam logic [2:0] OpRor = 3'b101;

  // Stage registers; index k holds the operation after level k has been applied.
  logic [L-1:0]                  r_valid;
  logic [L-1:0]                  r_ill;
  logic [L-1:0]                  r_sign;
  logic [L-1:0][WIDTH-1:0]       r_data;
  logic [L-1:0][L-1:0]           r_amt;
  logic [L-1:0][2:0]             r_op;
  logic [L-1:0][TAG_W-1:0]       r_tag;

  // Inputs to each level: the port bundle for level 0, the prior register otherwise.
  logic [L-1:0]                  w_src_valid;
  logic [L-1:0]                  w_src_ill;
  logic [L-1:0]                  w_src_sign;
  logic [L-1:0][WIDTH-1:0]       w_src_data;
  logic [L-1:0][L-1:0]           w_src_amt;
  logic [L-1:0][2:0]             w_src_op;
  logic [L-1:0][TAG_W-1:0]       w_src_tag;
  logic [L-1:0][WIDTH-1:0]       w_res_data;

  logic w_advance;
  logic w_in_illegal;

  assign w_advance    = !r_valid[L-1] || out_ready;
  assign w_in_illegal = !(in_op inside {OpSll, OpSrl, OpSra, OpRol, OpRor});

  always_comb begin
    w_src_valid[0] = in_valid;
    w_src_ill[0]   = w_in_illegal;
    w_src_sign[0]  = in_data[WIDTH-1];
    w_src_data[0]  = in_data;
    w_src_amt[0]   = in_amt;
    w_src_op[0]    = in_op;
    w_src_tag[0]   = in_tag;
    for (int unsigned k = 1; k < L; k++) begin
      w_src_valid[k] = r_valid[k-1];
      w_src_ill[k]   = r_ill[k-1];
      w_src_sign[k]  = r_sign[k-1];
      w_src_data[k]  = r_data[k-1];
      w_src_amt[k]   = r_amt[k-1];
      w_src_op[k]    = r_op[k-1];
      w_src_tag[k]   = r_tag[k-1];
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_level
    localparam int unsigned Sh = 2 ** k;
    logic [WIDTH-1:0] w_res;

    always_comb begin
      w_res = w_src_data[k];
      if (w_src_amt[k][k] && !w_src_ill[k]) begin
        case (w_src_op[k])
          OpSll:   w_res = w_src_data[k] << Sh;
          OpSrl:   w_res = w_src_data[k] >> Sh;
          // Fill with the original operand's sign, not this level's MSB.
          OpSra:   w_res = {{Sh{w_src_sign[k]}}, w_src_data[k][WIDTH-1:Sh]};
          OpRol:   w_res = {w_src_data[k][WIDTH-1-Sh:0], w_src_data[k][WIDTH-1:WIDTH-Sh]};
          OpRor:   w_res = {w_src_data[k][Sh-1:0], w_src_data[k][WIDTH-1:Sh]};
          default: w_res = w_src_data[k];
        endcase
      end
    end

    assign w_res_data[k] = w_res;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_ill   <= '0;
      r_sign  <= '0;
      r_data  <= '0;
      r_amt   <= '0;
      r_op    <= '0;
      r_tag   <= '0;
    end else if (w_advance) begin
      r_valid <= w_src_valid;
      r_ill   <= w_src_ill;
      r_sign  <= w_src_sign;
      r_data  <= w_res_data;
      r_amt   <= w_src_amt;
      r_op    <= w_src_op;
      r_tag   <= w_src_tag;
    end
  end

  assign in_ready    = w_advance;
  assign out_valid   = r_valid[L-1];
  assign out_data    = r_data[L-1];
  assign out_tag     = r_tag[L-1];
  assign out_illegal = r_ill[L-1];

  // Final-stage control fields are not consumed downstream.
  logic w_unused_bits;
  assign w_unused_bits = ^{r_amt[L-1], r_op[L-1], r_sign[L-1]};

`ifdef SHIFTER_ZERO_FLAG_EN
  logic r_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_zero <= 1'b0;
    end else if (w_advance) begin
      r_zero <= (w_res_data[L-1] == '0);
    end
  end

  assign out_zero = r_zero;
`endif

endmodule
